branch_predictor: RTL
=====================

// Module: branch_predictor
// PURPOSE
//  Fetch-side dynamic branch predictor: the consumer of branch resolution produced in EX.
//  IF looks up if_pc and gets pred_taken/pred_target in the same cycle.
//  EX returns the actual outcome (taken, target) plus the prediction carried down the pipe.
//  The block trains a direct-mapped BTB with 2-bit saturating counters, flags mispredicts,
//  supplies the corrected fetch PC, and keeps branch/mispredict performance counters.
// PARAMETERS
//  XLEN         32  datapath/PC width
//  BTB_ENTRIES  16  BTB depth; power of 2, >=2; IDX = $clog2(BTB_ENTRIES)
//  CNT_W        32  width of performance counters
// PORTS
//  clk              in   1      clock, all state updates on rising edge
//  rst_n            in   1      asynchronous active-low reset
//  if_pc            in   XLEN   fetch PC to predict
//  pred_taken       out  1      predicted taken for if_pc
//  pred_target      out  XLEN   predicted next fetch PC
//  ex_valid         in   1      a conditional branch is in EX and not stalled/flushed
//  ex_pc            in   XLEN   PC of the branch in EX
//  ex_taken         in   1      resolved outcome from EX
//  ex_target        in   XLEN   resolved target from EX (pc+imm)
//  ex_pred_taken    in   1      prediction that was made for this branch in IF
//  ex_pred_target   in   XLEN   predicted target that was made in IF
//  btb_flush        in   1      invalidate all BTB entries (e.g. FENCE.I)
//  mispredict       out  1      EX branch was mispredicted; flush IF/ID
//  redirect_pc      out  XLEN   correct next PC when mispredict=1
//  branch_count     out  CNT_W  number of resolved branches
//  mispredict_count out  CNT_W  number of mispredicts
// BEHAVIOUR
//  Entry = {valid, tag, target[XLEN], ctr[1:0]}; index = pc[IDX+1:2], tag = pc[XLEN-1:IDX+2].
//  Lookup (combinational, 0-cycle): hit = valid[i] && tag[i]==if_pc tag.
//   pred_taken = hit && ctr[1]; pred_target = pred_taken ? target[i] : if_pc+4 (mod 2^XLEN).
//  Resolution (combinational): mispredict = ex_valid && (ex_taken!=ex_pred_taken ||
//   (ex_taken && ex_target!=ex_pred_target)). redirect_pc = ex_taken ? ex_target : ex_pc+4;
//   when mispredict=0, redirect_pc still shows this value, but it is ignored by the consumer.
//  Update (rising edge, when ex_valid=1, index/tag taken from ex_pc):
//   hit: ctr saturating +1 if taken (cap 2'b11), -1 if not (floor 2'b00); target<=ex_target if taken.
//   miss & taken: allocate/overwrite: valid=1, tag, target=ex_target, ctr=2'b10.
//   miss & not taken: no change to BTB.
//  Counters: branch_count +1 per ex_valid; mispredict_count +1 per mispredict; both saturate
//   at all-ones (no wrap).
//  Simultaneous events:
//   - lookup and update to the same index in the same cycle: lookup returns the pre-update
//     entry. There is no bypass.
//   - btb_flush with ex_valid: flush wins. All valid bits clear and no allocate takes place.
//     Perf counters still update. Counter and target arrays are not cleared by flush.
//   - if_pc and ex_pc are misaligned (bits[1:0]!=0): bits are ignored; no error.
//  Reset (rst_n=0, async): all valid=0, all ctr=2'b01, targets=0, tags=0, both perf counters=0.
//   Outputs during reset follow the combinational rules: pred_taken=0, pred_target=if_pc+4.
//   mispredict/redirect_pc follow the EX inputs; the pipeline holds ex_valid=0 during reset.
//   Reset asserted mid-update: the update is discarded. Release is synchronous to clk
//   in the SoC reset tree.
// TESTING
//  1 Reset then lookup if_pc=0x100 -> pred_taken=0, pred_target=0x104, counters=0.
//  2 ex_valid, ex_pc=0x100, taken, target=0x80, pred_taken=0 -> mispredict=1,
//    redirect_pc=0x80; next cycle if_pc=0x100 -> pred_taken=1, pred_target=0x80.
//  3 Same branch resolved not-taken 2x -> ctr 10->01->00; then lookup pred_taken=0;
//    3 taken resolutions -> ctr saturates at 11; mispredict_count tracks each mismatch.
//  4 Aliasing (BTB_ENTRIES=16): train 0x100 taken, then 0x140 taken (same index) ->
//    0x100 now misses (pred_target=0x104); 0x140 hits with its own target.
//  5 Target change: hit taken with ex_target=0x200 and ex_pred_target=0x80 -> mispredict=1,
//    redirect_pc=0x200, entry target updated to 0x200.
//  6 btb_flush with ex_valid taken miss in the same cycle -> no entry valid afterwards;
//    branch_count +1; assert rst_n low mid-run -> all state at reset values immediately.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, mispredict detection and perf counters
module branch_predictor #(
   parameter int XLEN        = 32,
   parameter int BTB_ENTRIES = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [XLEN-1:0]  if_pc,
   output logic             pred_taken,
   output logic [XLEN-1:0]  pred_target,
   input  logic             ex_valid,
   input  logic [XLEN-1:0]  ex_pc,
   input  logic             ex_taken,
   input  logic [XLEN-1:0]  ex_target,
   input  logic             ex_pred_taken,
   input  logic [XLEN-1:0]  ex_pred_target,
   input  logic             btb_flush,
   output logic             mispredict,
   output logic [XLEN-1:0]  redirect_pc,
   output logic [CNT_W-1:0] branch_count,
   output logic [CNT_W-1:0] mispredict_count
);
   localparam int IDX   = $clog2(BTB_ENTRIES);
   localparam int TAG_W = XLEN - IDX - 2;
   logic [BTB_ENTRIES-1:0] valid;
   logic [TAG_W-1:0]       tag    [BTB_ENTRIES];
   logic [XLEN-1:0]        target [BTB_ENTRIES];
   logic [1:0]             ctr    [BTB_ENTRIES];
   logic [IDX-1:0]         if_idx, ex_idx;
   logic [TAG_W-1:0]       if_tag, ex_tag;
   logic                   ex_hit;
   assign if_idx = if_pc[IDX+1:2];
   assign if_tag = if_pc[XLEN-1:IDX+2];
   assign ex_idx = ex_pc[IDX+1:2];
   assign ex_tag = ex_pc[XLEN-1:IDX+2];
   assign ex_hit = valid[ex_idx] && tag[ex_idx] == ex_tag;
   // zero-cycle lookup from pre-update state, plus resolution of the branch in EX
   always_comb begin
      pred_taken  = valid[if_idx] && tag[if_idx] == if_tag && ctr[if_idx][1];
      pred_target = pred_taken ? target[if_idx] : if_pc + XLEN'(4);
      mispredict  = ex_valid && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target));
      redirect_pc = ex_taken ? ex_target : ex_pc + XLEN'(4);
   end
   // BTB training; a flush overrides any update arriving in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            tag[i]    <= '0;
            target[i] <= '0;
            ctr[i]    <= 2'b01;
         end
      end else if (btb_flush) begin
         valid <= '0;
      end else if (ex_valid && ex_hit) begin
         ctr[ex_idx] <= ex_taken ? ctr[ex_idx] + {1'b0, ctr[ex_idx] != 2'b11}
                                 : ctr[ex_idx] - {1'b0, ctr[ex_idx] != 2'b00};
         if (ex_taken) target[ex_idx] <= ex_target;
      end else if (ex_valid && ex_taken) begin
         valid[ex_idx]  <= 1'b1;
         tag[ex_idx]    <= ex_tag;
         target[ex_idx] <= ex_target;
         ctr[ex_idx]    <= 2'b10;
      end
   end
   // saturating performance counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else begin
         if (ex_valid && branch_count != '1) branch_count <= branch_count + CNT_W'(1);
         if (mispredict && mispredict_count != '1) mispredict_count <= mispredict_count + CNT_W'(1);
      end
   end
endmodule
